// File: rtl/leading_count_normalizer_if.sv
`default_nettype none
// ============================================================================
// Module   : leading_count_normalizer_if
// Purpose  : Operand/result handshake bundle for leading_count_normalizer.
// Revision : 1.0 - initial release
// ============================================================================
interface leading_count_normalizer_if #(
  parameter int IN_WIDTH = 32
);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [IN_WIDTH-1:0] in_data;
  logic [1:0]          in_mode;
  logic                out_valid;
  logic                out_ready;
  logic [CNT_W-1:0]    out_count;
  logic [IN_WIDTH-1:0] out_norm;
  logic                out_all;

  // Producer/consumer side (drives operands, accepts results)
  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_count, out_norm, out_all
  );

  // Normalizer side
  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_count, out_norm, out_all
  );
endinterface
`default_nettype wire

// File: rtl/leading_count_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : leading_count_normalizer
// Purpose  : Multi-cycle chunked leading/trailing zero/one counter + normalizer.
// Revision : 1.0 - initial release
// ============================================================================
module leading_count_normalizer #(
  parameter int IN_WIDTH = 32,
  parameter int CHUNK    = 8
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  leading_count_normalizer_if.slave  bus
);
  localparam int CNT_W = $clog2(IN_WIDTH + 1);
  localparam int N     = (IN_WIDTH + CHUNK - 1) / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int REM   = IN_WIDTH % CHUNK;
  // Low bits of a short final chunk lie past the word; forcing them to 1 bounds the scan.
  localparam logic [CHUNK-1:0] PAD_MASK =
    (REM == 0) ? '0 : CHUNK'((64'd1 << (CHUNK - REM)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [IN_WIDTH-1:0] sh_q,        sh_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic [IN_WIDTH-1:0] out_norm_q,  out_norm_d;
  logic                out_all_q,   out_all_d;

  logic [IN_WIDTH-1:0] t_word;
  logic [CHUNK-1:0]    chunk;
  logic                last_chunk;
  int                  z;
  int                  room;

  always_comb begin
    t_word = bus.in_data;
    if (bus.in_mode[1]) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        t_word[i] = bus.in_data[IN_WIDTH-1-i];
      end
    end
    if (bus.in_mode[0]) begin
      t_word = ~t_word;
    end
  end

  always_comb begin
    last_chunk = (idx_q == IDX_W'(N - 1));
    chunk      = sh_q[IN_WIDTH-1 -: CHUNK] | (last_chunk ? PAD_MASK : '0);
    z          = CHUNK;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        z = CHUNK - 1 - i;
      end
    end
    room = IN_WIDTH - int'(cnt_q);
    if (z > room) begin
      z = room;
    end
  end

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    out_count_d = out_count_q;
    out_norm_d  = out_norm_q;
    out_all_d   = out_all_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          sh_d    = t_word;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if ((chunk == '0) && !last_chunk) begin
          sh_d  = sh_q << CHUNK;
          cnt_d = cnt_q + CNT_W'(CHUNK);
          idx_d = idx_q + IDX_W'(1);
        end else begin
          sh_d        = sh_q << z;
          cnt_d       = cnt_q + CNT_W'(z);
          out_count_d = cnt_q + CNT_W'(z);
          out_norm_d  = sh_q << z;
          out_all_d   = ((int'(cnt_q) + z) == IN_WIDTH);
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_count_d = '0;
          out_norm_d  = '0;
          out_all_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_count_d = '0;
        out_norm_d  = '0;
        out_all_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      out_count_q <= '0;
      out_norm_q  <= '0;
      out_all_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
      out_norm_q  <= out_norm_d;
      out_all_q   <= out_all_d;
    end
  end

  // Gated by rst_n so in_ready is low during reset yet high on the first cycle after release.
  assign bus.in_ready  = rst_n && (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_count = out_count_q;
  assign bus.out_norm  = out_norm_q;
  assign bus.out_all   = out_all_q;

endmodule
`default_nettype wire

// File: tb/tb_leading_count_normalizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_leading_count_normalizer
// Purpose  : Directed self-checking bench for 32/8 and 20/8 normalizer builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_leading_count_normalizer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  leading_count_normalizer_if #(.IN_WIDTH(32)) if32 ();
  leading_count_normalizer_if #(.IN_WIDTH(20)) if20 ();

  leading_count_normalizer #(.IN_WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if32.slave)
  );

  leading_count_normalizer #(.IN_WIDTH(20), .CHUNK(8)) u_dut20 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if20.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // sel=0 drives the 32-bit build, sel=1 the 20-bit build.
  task automatic set_in(input bit sel, input logic v, input logic [31:0] d, input logic [1:0] m);
    if (sel) begin
      if20.in_valid = v; if20.in_data = d[19:0]; if20.in_mode = m;
    end else begin
      if32.in_valid = v; if32.in_data = d;       if32.in_mode = m;
    end
  endtask

  function automatic logic [31:0] get_norm(input bit sel);
    return sel ? {12'h0, if20.out_norm} : if32.out_norm;
  endfunction

  function automatic logic [5:0] get_count(input bit sel);
    return sel ? {1'b0, if20.out_count} : if32.out_count;
  endfunction

  // Issue one operand, measure edges until out_valid, check the result fields.
  task automatic run_op(input string tag, input bit sel, input logic [31:0] d, input logic [1:0] m,
                        input int exp_cnt, input logic [31:0] exp_norm, input logic exp_all,
                        input int exp_lat);
    int lat;
    int wait_n;
    logic ov;
    @(negedge clk);
    wait_n = 0;
    while (!(sel ? if20.in_ready : if32.in_ready) && wait_n < 20) begin
      @(negedge clk);
      wait_n++;
    end
    check_eq({tag, "_ready"}, 64'(sel ? if20.in_ready : if32.in_ready), 64'd1);
    set_in(sel, 1'b1, d, m);
    @(posedge clk);
    #1;
    // Operand and mode must have been sampled at the handshake only.
    set_in(sel, 1'b0, ~d, ~m);
    lat = 0;
    ov  = 1'b0;
    while (!ov && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      ov = sel ? if20.out_valid : if32.out_valid;
    end
    check_eq({tag, "_lat"},   64'(lat), 64'(exp_lat));
    check_eq({tag, "_count"}, 64'(get_count(sel)), 64'(exp_cnt));
    check_eq({tag, "_norm"},  64'(get_norm(sel)), 64'(exp_norm));
    check_eq({tag, "_all"},   64'(sel ? if20.out_all : if32.out_all), 64'(exp_all));
  endtask

  // With out_ready high, the result is taken at the next edge.
  task automatic consume(input string tag, input bit sel);
    @(posedge clk);
    #1;
    check_eq({tag, "_ov_clr"},  64'(sel ? if20.out_valid : if32.out_valid), 64'd0);
    check_eq({tag, "_cnt_clr"}, 64'(get_count(sel)), 64'd0);
    check_eq({tag, "_rdy_back"}, 64'(sel ? if20.in_ready : if32.in_ready), 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 2'b00);
    set_in(1'b1, 1'b0, 32'h0, 2'b00);
    if32.out_ready = 1'b1;
    if20.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready",  64'(if32.in_ready),  64'd0);
    check_eq("rst_out_valid", 64'(if32.out_valid), 64'd0);
    check_eq("rst_out_count", 64'(if32.out_count), 64'd0);
    check_eq("rst_out_norm",  64'(if32.out_norm),  64'd0);
    check_eq("rst_out_all",   64'(if32.out_all),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", 64'(if32.in_ready), 64'd1);

    run_op("lz_mid",   1'b0, 32'h0001_0000, 2'b00, 15, 32'h8000_0000, 1'b0, 2);
    consume("lz_mid", 1'b0);
    run_op("lz_zero",  1'b0, 32'h0000_0000, 2'b00, 32, 32'h0000_0000, 1'b1, 4);
    consume("lz_zero", 1'b0);
    run_op("lo",       1'b0, 32'hFFFF_FFF0, 2'b01, 28, 32'hF000_0000, 1'b0, 4);
    consume("lo", 1'b0);
    run_op("tz",       1'b0, 32'h0000_0100, 2'b10, 8,  32'h8000_0000, 1'b0, 2);
    consume("tz", 1'b0);
    run_op("to",       1'b0, 32'h0000_00FF, 2'b11, 8,  32'hFFFF_FF00, 1'b0, 2);
    consume("to", 1'b0);
    run_op("lz_msb",   1'b0, 32'h8000_0000, 2'b00, 0,  32'h8000_0000, 1'b0, 1);
    consume("lz_msb", 1'b0);
    run_op("lo_full",  1'b0, 32'hFFFF_FFFF, 2'b01, 32, 32'h0000_0000, 1'b1, 4);
    consume("lo_full", 1'b0);

    run_op("w20_zero", 1'b1, 32'h0000_0000, 2'b00, 20, 32'h0000_0000, 1'b1, 3);
    consume("w20_zero", 1'b1);
    run_op("w20_lsb",  1'b1, 32'h0000_0001, 2'b00, 19, 32'h0008_0000, 1'b0, 3);
    consume("w20_lsb", 1'b1);

    // Backpressure: result must hold while new operands are offered.
    if32.out_ready = 1'b0;
    run_op("bp", 1'b0, 32'h0001_0000, 2'b00, 15, 32'h8000_0000, 1'b0, 2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 32'h0000_0001 << k, 2'b01);
      @(posedge clk);
      #1;
      check_eq("bp_hold_ov",    64'(if32.out_valid), 64'd1);
      check_eq("bp_hold_cnt",   64'(if32.out_count), 64'd15);
      check_eq("bp_hold_norm",  64'(if32.out_norm),  64'h8000_0000);
      check_eq("bp_hold_ready", 64'(if32.in_ready),  64'd0);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 32'h0, 2'b00);
    if32.out_ready = 1'b1;
    consume("bp", 1'b0);

    // Reset in the middle of a scan aborts the operation.
    @(negedge clk);
    set_in(1'b0, 1'b1, 32'h0, 2'b00);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b0, 32'h0, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ov",    64'(if32.out_valid), 64'd0);
    check_eq("abort_cnt",   64'(if32.out_count), 64'd0);
    check_eq("abort_norm",  64'(if32.out_norm),  64'd0);
    check_eq("abort_all",   64'(if32.out_all),   64'd0);
    check_eq("abort_ready", 64'(if32.in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("abort_rel_ready", 64'(if32.in_ready), 64'd1);
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        if (if32.out_valid) seen++;
      end
      check_eq("abort_no_result", 64'(seen), 64'd0);
    end
    run_op("post_abort", 1'b0, 32'h8000_0000, 2'b00, 0, 32'h8000_0000, 1'b0, 1);
    consume("post_abort", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
